// File: rtl/reg_debug_access_pkg.sv
// Shared encodings for the debug register-file initiator: command ops, FSM states
// and the default widths of the core register file.
package reg_debug_access_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_DUMP    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_READ,
    ST_WRITE,
    ST_DUMP,
    ST_RSP
  } state_t;

endpackage

// File: rtl/reg_debug_halt_timer.sv
// Loadable down-counter bounding how long we wait for the core to acknowledge a halt.
// TIMEOUT = 0 disables expiry entirely.
module reg_debug_halt_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 2);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(TIMEOUT);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Loaded with TIMEOUT, so zero is reached after TIMEOUT waiting cycles.
  assign expired = (TIMEOUT != 0) && (count_reg == '0);

endmodule

// File: rtl/reg_debug_access.sv
// Debug-side initiator for the core register file: halts the core, then performs
// single reads, writes or a full register dump and returns results on a response channel.
module reg_debug_access
  import reg_debug_access_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int NUM_REGS     = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_data_write
);

  state_t            state, state_next;
  op_t               op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              cmd_ready_reg;
  logic              halt_req_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;
  logic              rsp_last_reg;
  logic              rsp_err_reg;

  logic accept, cmd_bad, dump_more;
  logic timer_load, timer_en, timer_expired;

  assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready_reg;
  assign cmd_bad   = (cmd_op == OP_ILLEGAL) || ((cmd_op == OP_WRITE) && (cmd_addr == '0));
  assign dump_more = (op_reg == OP_DUMP) && !rsp_last_reg && !rsp_err_reg;

  reg_debug_halt_timer #(
    .TIMEOUT (HALT_TIMEOUT)
  ) u_halt_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    timer_load    = 1'b0;
    timer_en      = 1'b0;
    rf_read_reg   = '0;
    rf_write_en   = 1'b0;
    rf_write_reg  = '0;
    rf_data_write = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = cmd_bad ? ST_RSP : ST_HALT_WAIT;
          timer_load = !cmd_bad;
        end
      end
      ST_HALT_WAIT: begin
        if (halt_ack) begin
          case (op_reg)
            OP_READ:  state_next = ST_READ;
            OP_WRITE: state_next = ST_WRITE;
            default:  state_next = ST_DUMP;
          endcase
        end else if (timer_expired) begin
          state_next = ST_RSP;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_READ: begin
        rf_read_reg = addr_reg;
        state_next  = ST_RSP;
      end
      ST_WRITE: begin
        rf_write_en   = 1'b1;
        rf_write_reg  = addr_reg;
        rf_data_write = wdata_reg;
        state_next    = ST_RSP;
      end
      ST_DUMP: begin
        // Core resumed mid-dump: re-arm the halt wait without touching the register file.
        if (!halt_ack) begin
          state_next = ST_HALT_WAIT;
          timer_load = 1'b1;
        end else begin
          rf_read_reg = idx_reg;
          state_next  = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_next = dump_more ? ST_DUMP : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg        <= OP_READ;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      idx_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      halt_req_reg  <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_addr_reg  <= '0;
      rsp_last_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_reg    <= op_t'(cmd_op);
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            idx_reg   <= '0;
            if (cmd_bad) begin
              rsp_err_reg  <= 1'b1;
              rsp_data_reg <= '0;
              rsp_addr_reg <= cmd_addr;
              rsp_last_reg <= 1'b1;
            end else begin
              halt_req_reg <= 1'b1;
              rsp_err_reg  <= 1'b0;
            end
          end
        end
        ST_HALT_WAIT: begin
          if (!halt_ack && timer_expired) begin
            rsp_err_reg  <= 1'b1;
            rsp_data_reg <= '0;
            rsp_addr_reg <= (op_reg == OP_DUMP) ? idx_reg : addr_reg;
            rsp_last_reg <= 1'b1;
          end
        end
        ST_READ: begin
          rsp_data_reg <= rf_read_data;
          rsp_addr_reg <= addr_reg;
          rsp_last_reg <= 1'b1;
          rsp_err_reg  <= 1'b0;
        end
        ST_WRITE: begin
          rsp_data_reg <= wdata_reg;
          rsp_addr_reg <= addr_reg;
          rsp_last_reg <= 1'b1;
          rsp_err_reg  <= 1'b0;
        end
        ST_DUMP: begin
          if (halt_ack) begin
            rsp_data_reg <= rf_read_data;
            rsp_addr_reg <= idx_reg;
            rsp_last_reg <= (idx_reg == ADDR_W'(NUM_REGS - 1));
            rsp_err_reg  <= 1'b0;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            if (dump_more) begin
              idx_reg <= idx_reg + ADDR_W'(1);
            end else begin
              halt_req_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign halt_req  = halt_req_reg;
  assign rsp_valid = (state == ST_RSP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rsp_last  = rsp_last_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_reg_debug_access.sv
// Randomized self-checking bench for reg_debug_access with a behavioural register-file
// model and an expected-contents array updated from the command semantics.
module tb_reg_debug_access;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          rsp_err;
  logic          halt_req;
  logic          halt_ack;
  logic [AW-1:0] rf_read_reg;
  logic [DW-1:0] rf_read_data;
  logic          rf_write_en;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_data_write;

  int checks = 0;
  int errors = 0;

  // Register file environment and the expected contents derived from commands.
  logic [DW-1:0] rf_mem [NR] = '{default: '0};
  logic [DW-1:0] exp_regs [NR];

  int            wr_cnt = 0;
  int            hreq_cnt = 0;
  int            bad_reads = 0;
  logic [AW-1:0] wr_last_reg = '0;

  always #5 clk = ~clk;

  reg_debug_access #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .HALT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_data_write(rf_data_write)
  );

  assign rf_read_data = rf_mem[rf_read_reg];

  always @(posedge clk) begin
    if (rf_write_en) begin
      rf_mem[rf_write_reg] <= rf_data_write;
      wr_cnt <= wr_cnt + 1;
      wr_last_reg <= rf_write_reg;
    end
    if (halt_req) hreq_cnt <= hreq_cnt + 1;
    if (!halt_ack && rf_read_reg != '0) bad_reads <= bad_reads + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
  endtask

  // Counts negedges until rsp_valid is seen; leaves the caller on that negedge.
  task automatic wait_rsp(input int budget, output int waited);
    bit ok = 0;
    waited = 0;
    while (waited < budget && !ok) begin
      @(negedge clk);
      waited++;
      if (rsp_valid) ok = 1;
    end
    if (!ok) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_rsp(input int stall, output logic [DW-1:0] d, output logic [AW-1:0] a,
                          output logic l, output logic e);
    d = rsp_data; a = rsp_addr; l = rsp_last; e = rsp_err;
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_stable", {24'd0, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err},
            {24'd0, 1'b1, d, a, l, e});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int stall, output logic [DW-1:0] d, output logic [AW-1:0] a,
                         output logic l, output logic e, output int lat);
    issue(op, addr, wdata);
    wait_rsp(40, lat);
    take_rsp(stall, d, a, l, e);
  endtask

  // Expected single-command result straight from the command rules.
  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           output logic [DW-1:0] d, output logic e);
    if (op == 2'b11 || (op == 2'b01 && addr == '0)) begin
      d = '0; e = 1'b1;
    end else if (op == 2'b01) begin
      exp_regs[addr] = wdata; d = wdata; e = 1'b0;
    end else begin
      d = exp_regs[addr]; e = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] d, md, wd;
    logic [AW-1:0] a, ad;
    logic [1:0]    op;
    logic          l, e, me;
    int            lat, w0, h0, b0;

    foreach (exp_regs[i]) exp_regs[i] = '0;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; halt_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {rf_data_write, 32'(rf_write_reg)} | {32'd0, 32'(rf_read_reg)},
          64'd0);
    check("reset_ctl", {56'd0, cmd_ready, rsp_valid, rsp_last, rsp_err, halt_req, rf_write_en, 2'b0},
          64'd0);
    check("reset_rsp", {27'd0, rsp_addr, rsp_data}, 64'd0);
    rstn = 1'b1;

    // Write then read back register 5.
    w0 = wr_cnt;
    run_cmd(2'b01, 5'd5, 32'hDEADBEEF, 0, d, a, l, e, lat);
    model_cmd(2'b01, 5'd5, 32'hDEADBEEF, md, me);
    check("wr_rsp", {d, 27'(a), l, e, 2'b0}, {md, 27'd5, 1'b1, me, 2'b0});
    check("wr_pulses", 64'(wr_cnt - w0), 64'd1);
    check("wr_reg", 64'(wr_last_reg), 64'd5);
    check("wr_lat", 64'(lat), 64'd3);
    check("wr_hreq_drop", {63'd0, halt_req}, 64'd0);
    run_cmd(2'b00, 5'd5, 32'd0, 1, d, a, l, e, lat);
    model_cmd(2'b00, 5'd5, 32'd0, md, me);
    check("rd_rsp", {d, 27'(a), l, e, 2'b0}, {md, 27'd5, 1'b1, me, 2'b0});
    check("rd_lat", 64'(lat), 64'd3);

    // x0 write and illegal op never halt the core or touch the register file.
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 2'b01 : 2'b11;
      w0 = wr_cnt; h0 = hreq_cnt;
      wd = $urandom;
      ad = (k == 0) ? 5'd0 : 5'($urandom);
      run_cmd(op, ad, wd, $urandom_range(0, 2), d, a, l, e, lat);
      model_cmd(op, ad, wd, md, me);
      check("bad_rsp", {d, 30'd0, l, e}, {md, 30'd0, 1'b1, me});
      check("bad_lat", 64'(lat), 64'd1);
      check("bad_side", {32'(wr_cnt - w0), 32'(hreq_cnt - h0)}, 64'd0);
    end

    // Halt timeout with halt_ack held low.
    halt_ack = 1'b0;
    issue(2'b00, 5'd3, 32'd0);
    wait_rsp(40, lat);
    check("to_lat", 64'(lat), 64'(TO + 2));
    check("to_hreq_hold", {63'd0, halt_req}, 64'd1);
    take_rsp(1, d, a, l, e);
    check("to_rsp", {62'd0, l, e}, 64'd3);
    check("to_hreq_drop", {63'd0, halt_req}, 64'd0);

    // halt_ack arriving after two cycles gives a normal read.
    issue(2'b00, 5'd5, 32'd0);
    repeat (2) @(negedge clk);
    halt_ack = 1'b1;
    wait_rsp(40, lat);
    take_rsp(0, d, a, l, e);
    model_cmd(2'b00, 5'd5, 32'd0, md, me);
    check("late_ack_rsp", {d, 27'(a), l, e, 2'b0}, {md, 27'd5, 1'b1, me, 2'b0});

    // Random single commands against the model.
    for (int k = 0; k < 24; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      ad = 5'($urandom);
      wd = $urandom;
      run_cmd(op, ad, wd, $urandom_range(0, 3), d, a, l, e, lat);
      model_cmd(op, ad, wd, md, me);
      check("rand_rsp", {d, 30'd0, l, e}, {md, 30'd0, 1'b1, me});
    end

    // Preload reg i = i*3 through the block itself.
    for (int i = 1; i < NR; i++) begin
      run_cmd(2'b01, 5'(i), 32'(i * 3), 0, d, a, l, e, lat);
      model_cmd(2'b01, 5'(i), 32'(i * 3), md, me);
    end
    check("preload_x0", 64'(exp_regs[0]), 64'd0);

    // Dump with random backpressure.
    issue(2'b10, 5'd0, 32'd0);
    for (int i = 0; i < NR; i++) begin
      wait_rsp(40, lat);
      if (i > 0) check("dump_gap", 64'(lat), 64'd2);
      take_rsp($urandom_range(0, 3), d, a, l, e);
      check("dump_beat", {a, d, l, e}, {5'(i), exp_regs[i], (i == NR - 1), 1'b0});
    end
    check("dump_end", {62'd0, halt_req, rsp_valid}, 64'd0);

    // halt_ack dropped after beat 10: stall without reads, then resume at 11.
    issue(2'b10, 5'd0, 32'd0);
    for (int i = 0; i < NR; i++) begin
      wait_rsp(40, lat);
      take_rsp(0, d, a, l, e);
      check("drop_beat", {a, d, l, e}, {5'(i), exp_regs[i], (i == NR - 1), 1'b0});
      if (i == 10) begin
        halt_ack = 1'b0;
        b0 = bad_reads;
        repeat (3) begin
          @(negedge clk);
          check("drop_stall", {62'd0, rsp_valid, halt_req}, 64'd1);
        end
        check("drop_no_reads", 64'(bad_reads - b0), 64'd0);
        halt_ack = 1'b1;
      end
    end

    // Reset during beat 7 of a dump.
    issue(2'b10, 5'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      wait_rsp(40, lat);
      take_rsp(0, d, a, l, e);
    end
    wait_rsp(40, lat);
    rstn = 1'b0;
    #1;
    check("mid_reset_ctl", {58'd0, cmd_ready, rsp_valid, rsp_last, rsp_err, halt_req, rf_write_en},
          64'd0);
    check("mid_reset_rsp", {27'd0, rsp_addr, rsp_data}, 64'd0);
    check("mid_reset_rf", {rf_data_write, 22'd0, rf_write_reg, rf_read_reg}, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cmd(2'b00, 5'd7, 32'd0, 1, d, a, l, e, lat);
    model_cmd(2'b00, 5'd7, 32'd0, md, me);
    check("post_reset_rd", {d, 27'(a), l, e, 2'b0}, {md, 27'd7, 1'b1, me, 2'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench time limit");
  end

endmodule
